// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
//   size_e       : access size encoding (3 is illegal)
//   byte_enables : per-lane write strobe for a size at a byte lane
//   load_extend  : shift a read word down to its lane and sign/zero extend
// Helpers work on MAX_N-bit words; callers cast to their own width.
package dmem_pkg;

  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_N     = 8 * MAX_LANES;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  // Strobe for the selected bytes; lanes = number of byte lanes in a word.
  function automatic logic [MAX_LANES-1:0] byte_enables(input size_e size,
                                                        input int unsigned lane,
                                                        input int unsigned lanes);
    logic [MAX_LANES-1:0] be;
    be = '0;
    case (size)
      BYTE:    be = MAX_LANES'(1) << lane;
      HALF:    be = MAX_LANES'(3) << lane;
      WORD:    be = (MAX_LANES'(1) << lanes) - MAX_LANES'(1);
      default: be = '0;
    endcase
    return be;
  endfunction

  // Lane shift followed by sign (or zero, when is_unsigned) extension.
  function automatic logic [MAX_N-1:0] load_extend(input logic [MAX_N-1:0] word,
                                                   input size_e size,
                                                   input int unsigned lane,
                                                   input logic is_unsigned);
    logic [MAX_N-1:0] sh;
    logic [MAX_N-1:0] res;
    sh = word >> (8 * lane);
    case (size)
      BYTE:    res = is_unsigned ? {{(MAX_N-8){1'b0}}, sh[7:0]}
                                 : {{(MAX_N-8){sh[7]}}, sh[7:0]};
      HALF:    res = is_unsigned ? {{(MAX_N-16){1'b0}}, sh[15:0]}
                                 : {{(MAX_N-16){sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load alignment: selects the addressed byte/half/word from a
// read word and extends it to N bits.
//   word        : raw word read from memory
//   size        : access size
//   lane        : byte lane of the access within the word
//   is_unsigned : zero-extend instead of sign-extend
//   rdata_c     : aligned, extended load data (combinational)
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter  int unsigned N      = 32,
  localparam int unsigned LANE_W = $clog2(N / 8)
) (
  input  logic [N-1:0]      word,
  input  size_e             size,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_unsigned,
  output logic [N-1:0]      rdata_c
);

  always_comb begin
    rdata_c = N'(load_extend(MAX_N'(word), size, 32'(lane), is_unsigned));
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory for the RV32 MEM stage. Byte/half/word loads
// and stores, byte-enable writes, sign/zero-extended loads, fault flagging,
// one in-order response per request after READ_LATENCY cycles.
//   clk, rstn       : clock, synchronous active-low reset
//   req_valid       : request present this cycle (no back-pressure)
//   req_write       : 1 = store, 0 = load
//   req_size        : BYTE/HALF/WORD, 3 is illegal
//   req_unsigned    : zero-extend loads
//   req_addr        : byte address
//   req_wdata       : store data (low bits used for narrow stores)
//   rsp_valid       : one-cycle response strobe
//   rsp_rdata       : extended load data, 0 for stores/faults/idle
//   rsp_fault       : misaligned, out of range or illegal size
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned N            = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_fault
);

  localparam int unsigned LANES  = N / 8;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  logic [N-1:0] mem [DEPTH];

  size_e             size_c;
  logic [IDX_W-1:0]  idx_c;
  logic [LANE_W-1:0] lane_c;
  logic [N-1:0]      word_addr_c;
  logic              misalign_c;
  logic              fault_c;
  logic [LANES-1:0]  be_c;
  logic [N-1:0]      wdata_rep_c;

  logic [N-1:0]      rd_word;
  logic              s1_valid;
  logic              s1_fault;
  logic              s1_load;
  size_e             s1_size;
  logic [LANE_W-1:0] s1_lane;
  logic              s1_unsigned;
  logic [N-1:0]      align_c;
  logic [N-1:0]      s1_data_c;

  // Request decode: word index, lane, fault conditions, byte enables.
  always_comb begin
    size_c      = size_e'(req_size);
    idx_c       = req_addr[LANE_W +: IDX_W];
    lane_c      = req_addr[LANE_W-1:0];
    word_addr_c = req_addr >> LANE_W;
    misalign_c  = ((size_c == HALF) && req_addr[0]) ||
                  ((size_c == WORD) && (lane_c != '0));
    fault_c     = (req_size == 2'd3) || misalign_c || (word_addr_c >= N'(DEPTH));
    be_c        = LANES'(byte_enables(size_c, 32'(lane_c), LANES));
  end

  // Replicate narrow store data across every lane so the enables pick it up.
  always_comb begin
    wdata_rep_c = req_wdata;
    for (int unsigned b = 0; b < LANES; b++) begin
      case (size_c)
        BYTE:    wdata_rep_c[8*b +: 8] = req_wdata[7:0];
        HALF:    wdata_rep_c[8*b +: 8] = req_wdata[8*(b%2) +: 8];
        default: wdata_rep_c[8*b +: 8] = req_wdata[8*b +: 8];
      endcase
    end
  end

  // Per-byte write; faulting stores and stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (rstn && req_valid && req_write && !fault_c) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (be_c[b]) begin
          mem[idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
        end
      end
    end
  end

  // Synchronous read; a store from the previous cycle has already landed.
  always_ff @(posedge clk) begin
    if (req_valid && !req_write) begin
      rd_word <= mem[idx_c];
    end
  end

  // First pipeline stage: control travelling alongside the read word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_fault    <= 1'b0;
      s1_load     <= 1'b0;
      s1_size     <= BYTE;
      s1_lane     <= '0;
      s1_unsigned <= 1'b0;
    end else begin
      s1_valid    <= req_valid;
      s1_fault    <= req_valid && fault_c;
      s1_load     <= req_valid && !req_write && !fault_c;
      s1_size     <= size_c;
      s1_lane     <= lane_c;
      s1_unsigned <= req_unsigned;
    end
  end

  dmem_load_align #(.N(N)) u_align (
    .word        (rd_word),
    .size        (s1_size),
    .lane        (s1_lane),
    .is_unsigned (s1_unsigned),
    .rdata_c     (align_c)
  );

  // Data is zero for stores, faults and idle slots.
  always_comb begin
    s1_data_c = s1_load ? align_c : '0;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic         s2_valid;
    logic         s2_fault;
    logic [N-1:0] s2_rdata;

    // Extra register stage after alignment.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        s2_valid <= 1'b0;
        s2_fault <= 1'b0;
        s2_rdata <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_fault <= s1_fault;
        s2_rdata <= s1_data_c;
      end
    end

    assign rsp_valid = s2_valid;
    assign rsp_fault = s2_fault;
    assign rsp_rdata = s2_rdata;
  end else begin : g_lat1
    assign rsp_valid = s1_valid;
    assign rsp_fault = s1_fault;
    assign rsp_rdata = s1_data_c;
  end

endmodule
